// File: rtl/down_counter16_pkg.sv
// Shared types and constants for the down_counter16 timer slice.
package down_counter16_pkg;

    localparam int DC16_WIDTH = 16;
    localparam int ONE        = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dec16.sv
// Combinational decrementer, the mirror of the PC incrementer; wraps modulo 2^WIDTH.
module dec16
    import down_counter16_pkg::*;
#(
    parameter int WIDTH = DC16_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    assign out = in - WIDTH'(ONE);

endmodule

// File: rtl/down_counter16.sv
// Loadable down-counter with a one-cycle done pulse at terminal count.
// Define DOWN_COUNTER16_RELOAD_EN for periodic auto-reload instead of stopping at zero.
module down_counter16
    import down_counter16_pkg::*;
#(
    parameter int WIDTH = DC16_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_e           state;
    logic [WIDTH-1:0] out_m1;
    logic             at_one;

`ifdef DOWN_COUNTER16_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    dec16 #(.WIDTH(WIDTH)) u_dec (
        .in  (out),
        .out (out_m1)
    );

    assign at_one = (out == WIDTH'(ONE));
    assign zero   = (out == '0);
    assign busy   = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            out   <= '0;
            state <= ST_IDLE;
            done  <= 1'b0;
`ifdef DOWN_COUNTER16_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                // A load always beats a decrement, so a terminal count is never flagged here.
                out   <= in;
                state <= (in != '0) ? ST_RUN : ST_IDLE;
`ifdef DOWN_COUNTER16_RELOAD_EN
                reload <= in;
`endif
            end else if (dec) begin
                if (state == ST_RUN) begin
                    if (at_one) begin
                        done <= 1'b1;
`ifdef DOWN_COUNTER16_RELOAD_EN
                        out   <= reload;
                        state <= ST_RUN;
`else
                        out   <= out_m1;
                        state <= ST_DONE;
`endif
                    end else begin
                        out   <= out_m1;
                        state <= ST_RUN;
                    end
                end else begin
                    // Raw wrapping mode from IDLE or DONE.
                    out   <= out_m1;
                    state <= ST_IDLE;
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_down_counter16.sv
// Directed table-driven bench for down_counter16 (both build variants).
module tb_down_counter16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, load, dec;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic         zero, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         dc;
        logic [W-1:0] din;
        logic [W-1:0] e_out;
        logic         e_zero;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t vq[$];

    down_counter16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .load  (load),
        .dec   (dec),
        .out   (out),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic l, input logic d, input logic [W-1:0] di,
                       input logic [W-1:0] eo, input logic ez, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.ld = l; v.dc = d; v.din = di;
        v.e_out = eo; v.e_zero = ez; v.e_busy = eb; v.e_done = ed;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic d, input logic [W-1:0] di);
        reset = r; load = l; dec = d; in = di;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles, pulses;
        logic prev_done;
        reset = 1'b1; load = 1'b0; dec = 1'b0; in = '0;

        //   rst ld dc in       out      z  b  d
        add(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 0, 0);
`ifndef DOWN_COUNTER16_RELOAD_EN
        add(0, 1, 0, 16'h0003, 16'h0003, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0002, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 1);
        add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 0, 0);  // dec in DONE wraps, no second done
        add(0, 1, 0, 16'h0005, 16'h0005, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0004, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0003, 0, 1, 0);
        add(0, 1, 1, 16'h0002, 16'h0002, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'h0001, 16'h0001, 0, 1, 0);
        add(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0);  // load 0 beats dec at out==1
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'h0001, 16'h0001, 0, 1, 0);
        add(1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);  // reset aborts, no done
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'h0002, 16'h0002, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'h0007, 16'h0007, 0, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0007, 0, 1, 0);
        add(0, 1, 0, 16'h0003, 16'h0003, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0002, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 1);
        add(0, 1, 0, 16'h0004, 16'h0004, 0, 1, 0);  // load during DONE restarts
`else
        add(0, 1, 0, 16'h0002, 16'h0002, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0002, 0, 1, 1);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0002, 0, 1, 1);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0002, 0, 1, 1);
        add(0, 0, 0, 16'h0000, 16'h0002, 0, 1, 0);
        add(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0);  // load 0 stops the period
        add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 0, 0);
        add(0, 1, 0, 16'h0001, 16'h0001, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 0, 1, 1);  // period of one
        add(1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].ld, vq[i].dc, vq[i].din);
            chk($sformatf("v%0d.out", i),  out,                 vq[i].e_out);
            chk($sformatf("v%0d.zero", i), {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, vq[i].e_zero});
            chk($sformatf("v%0d.busy", i), {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, vq[i].e_busy});
            chk($sformatf("v%0d.done", i), {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, vq[i].e_done});
        end

        // Long count with dec held: count edges to done, confirm pulse is single.
        step(1, 0, 0, '0);
        step(0, 1, 0, 16'h0010);
        cycles = 0; pulses = 0; prev_done = 1'b0;
`ifndef DOWN_COUNTER16_RELOAD_EN
        while (done !== 1'b1 && cycles < 40) begin
            step(0, 0, 1, '0);
            cycles++;
        end
        chk("long.edges", W'(cycles), W'(16));
        chk("long.out", out, 16'h0000);
        step(0, 0, 0, '0);
        chk("long.single", {{(W-1){1'b0}}, done}, '0);
`else
        for (int k = 0; k < 48; k++) begin
            step(0, 0, 1, '0);
            if (done === 1'b1) pulses++;
            if (done === 1'b1 && prev_done === 1'b1) cycles++;
            prev_done = done;
        end
        chk("period.pulses", W'(pulses), W'(3));
        chk("period.back2back", W'(cycles), W'(0));
        chk("period.out", out, 16'h0010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
